// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//
// Coin-return engine. Takes a money amount (refund or change) and ejects it
// as a sequence of physical coins, largest denomination first (20/10/5/1).
// Each coin is requested with a one-hot eject line that is held until the
// ejector acknowledges it. Consecutive requests are separated by PULSE_GAP
// idle cycles plus one select cycle, so a repeated denomination always shows
// a low gap.
//
// Parameters
//   AMT_W      width of amount / remaining (must be >= 5 so 20 is representable)
//   PULSE_GAP  idle cycles between consecutive coin requests (0 = no gap state)
//
// Ports
//   clk        system clock, rising edge
//   i_rst      asynchronous active-high reset
//   m_rst      synchronous machine reset, same effect as i_rst
//   start      dispense request, sampled only when idle
//   amount     value to return, latched on an accepted start
//   coin_ack   ejector confirms the current coin dropped
//   out_1/5/10/20  eject request per denomination (at most one high)
//   busy       high from accepted start until the transaction ends
//   done       one-cycle pulse at the end of a transaction
//   remaining  value still to be ejected
//   coins_out  coins ejected in the current/last transaction (saturating)
// ---------------------------------------------------------------------------
module change_dispenser #(
  parameter int AMT_W     = 8,
  parameter int PULSE_GAP = 2
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             m_rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             coin_ack,
  output logic             out_1,
  output logic             out_5,
  output logic             out_10,
  output logic             out_20,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] remaining,
  output logic [7:0]       coins_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_EJECT  = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  // The gap counter runs from PULSE_GAP-1 down to 0.
  localparam int                GAP_W    = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = (PULSE_GAP > 0) ? GAP_W'(PULSE_GAP - 1) : '0;

  logic [1:0]       state;
  logic [GAP_W-1:0] gap_cnt;

  // Denomination chosen from the current remaining value. remaining does not
  // change while a coin is outstanding, so the same value selected in SELECT
  // is the one subtracted on the acknowledge in EJECT.
  logic [AMT_W-1:0] denom;
  logic [3:0]       denom_onehot;   // {20, 10, 5, 1}
  logic [7:0]       coins_inc;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    denom        = AMT_W'(1);
    denom_onehot = 4'b0001;
    if (remaining >= AMT_W'(20)) begin
      denom        = AMT_W'(20);
      denom_onehot = 4'b1000;
    end else if (remaining >= AMT_W'(10)) begin
      denom        = AMT_W'(10);
      denom_onehot = 4'b0100;
    end else if (remaining >= AMT_W'(5)) begin
      denom        = AMT_W'(5);
      denom_onehot = 4'b0010;
    end
  end

  assign coins_inc = (coins_out == 8'hFF) ? 8'hFF : coins_out + 8'd1;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      gap_cnt   <= '0;
      out_1     <= 1'b0;
      out_5     <= 1'b0;
      out_10    <= 1'b0;
      out_20    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      coins_out <= '0;
    end else if (m_rst) begin
      // Abort: same values as the asynchronous reset, no done pulse.
      state     <= S_IDLE;
      gap_cnt   <= '0;
      out_1     <= 1'b0;
      out_5     <= 1'b0;
      out_10    <= 1'b0;
      out_20    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      coins_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            coins_out <= '0;
            if (amount != '0) begin
              remaining <= amount;
              busy      <= 1'b1;
              state     <= S_SELECT;
            end else begin
              // Nothing to return: finish immediately without a coin.
              done <= 1'b1;
            end
          end
        end

        S_SELECT: begin
          {out_20, out_10, out_5, out_1} <= denom_onehot;
          state <= S_EJECT;
        end

        S_EJECT: begin
          // Leaving EJECT on the acknowledge means a held-high coin_ack
          // retires only the one coin of this entry.
          if (coin_ack) begin
            {out_20, out_10, out_5, out_1} <= 4'b0000;
            remaining <= remaining - denom;
            coins_out <= coins_inc;
            if (remaining == denom) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else if (PULSE_GAP == 0) begin
              state <= S_SELECT;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_SELECT;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser
//
// Directed bench for change_dispenser. A transaction-level model tracks what
// the outputs must be (amount left, coins paid, which coin is requested and
// how many cycles until the next request) and is compared with the DUT on
// every cycle. Directed scenarios add hand-computed expectations for coin
// sequences, request lengths and gap lengths.
// ---------------------------------------------------------------------------
module tb_change_dispenser;

  localparam int AMT_W     = 8;
  localparam int PULSE_GAP = 2;

  logic             clk = 1'b0;
  logic             i_rst;
  logic             m_rst;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             coin_ack = 1'b0;
  logic             out_1, out_5, out_10, out_20;
  logic             busy, done;
  logic [AMT_W-1:0] remaining;
  logic [7:0]       coins_out;

  change_dispenser #(.AMT_W(AMT_W), .PULSE_GAP(PULSE_GAP)) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .m_rst     (m_rst),
    .start     (start),
    .amount    (amount),
    .coin_ack  (coin_ack),
    .out_1     (out_1),
    .out_5     (out_5),
    .out_10    (out_10),
    .out_20    (out_20),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .coins_out (coins_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- ejector responder ----------------
  // auto_ack: pulse coin_ack for one cycle once a request has been seen
  // high on ack_delay+1 samples. force_ack: hold coin_ack high.
  bit auto_ack  = 1'b0;
  bit force_ack = 1'b0;
  int ack_delay = 0;
  bit pulse     = 1'b0;
  int hold      = 0;

  always @(negedge clk) begin
    if (pulse) begin
      pulse = 1'b0;
      hold  = 0;
    end else if (auto_ack && (out_1 || out_5 || out_10 || out_20)) begin
      if (hold >= ack_delay) begin
        pulse = 1'b1;
        hold  = 0;
      end else begin
        hold++;
      end
    end else begin
      hold = 0;
    end
    coin_ack = pulse | force_ack;
  end

  // ---------------- transaction model ----------------
  function automatic int largest_coin(input int r);
    if (r >= 20) return 20;
    if (r >= 10) return 10;
    if (r >= 5)  return 5;
    return 1;
  endfunction

  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_rem   = 0;
  int m_coins = 0;
  int m_req   = 0;   // value of coin currently requested, 0 = none
  int m_wait  = 0;   // edges until the next request appears

  always @(posedge clk) begin
    if (i_rst || m_rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_coins = 0; m_req = 0; m_wait = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_coins = 0;
          if (amount == 0) m_done = 1'b1;
          else begin
            m_busy = 1'b1;
            m_rem  = int'(amount);
            m_wait = 1;
          end
        end
      end else if (m_req != 0) begin
        if (coin_ack) begin
          m_rem   = m_rem - m_req;
          m_coins = (m_coins == 255) ? 255 : m_coins + 1;
          m_req   = 0;
          if (m_rem == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end else begin
            m_wait = PULSE_GAP + 1;
          end
        end
      end else begin
        m_wait--;
        if (m_wait == 0) m_req = largest_coin(m_rem);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  logic [3:0] exp_o;
  always @(negedge clk) begin
    if (!i_rst) begin
      exp_o = {m_req == 20, m_req == 10, m_req == 5, m_req == 1};
      check("cycle",
            {10'd0, out_20, out_10, out_5, out_1, busy, done, remaining, coins_out},
            {10'd0, exp_o, m_busy, m_done, AMT_W'(m_rem), 8'(m_coins)});
    end
  end

  // ---------------- observation monitor ----------------
  int obs_q[$];    // denomination of each request, in order
  int hi_q[$];     // samples each request stayed high
  int lo_q[$];     // low samples between consecutive requests of a transaction
  int rem_q[$];    // successive values of remaining
  int done_cnt = 0;
  logic [3:0] mon_o;
  logic [3:0] prev_o = 4'b0;
  logic [AMT_W-1:0] prev_rem = '0;
  int  hi_run = 0;
  int  lo_run = 0;
  bit  had_fall = 1'b0;

  always @(negedge clk) begin
    if (!i_rst) begin
      mon_o = {out_20, out_10, out_5, out_1};
      if (mon_o != 4'b0) begin
        hi_run++;
        if (prev_o == 4'b0) begin
          obs_q.push_back(mon_o[3] ? 20 : mon_o[2] ? 10 : mon_o[1] ? 5 : 1);
          if (had_fall) lo_q.push_back(lo_run);
        end
      end else begin
        if (prev_o != 4'b0) begin
          hi_q.push_back(hi_run);
          hi_run   = 0;
          lo_run   = 0;
          had_fall = 1'b1;
        end
        if (had_fall) lo_run++;
      end
      if (!busy) had_fall = 1'b0;
      if (done) done_cnt++;
      if (remaining != prev_rem) rem_q.push_back(int'(remaining));
      prev_o   = mon_o;
      prev_rem = remaining;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input int amt);
    @(negedge clk);
    start  = 1'b1;
    amount = AMT_W'(amt);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_seq(input string name, input int from, input int exp_q[$]);
    check({name, "_len"}, 32'(obs_q.size() - from), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (from + i < obs_q.size()) check({name, "_coin"}, 32'(obs_q[from + i]), 32'(exp_q[i]));
    end
  endtask

  // ---------------- test sequence ----------------
  int o0, d0, h0, l0, r0;
  int exp_seq[$];
  int exp_rem[$];
  bit got;

  initial begin
    i_rst  = 1'b1;
    m_rst  = 1'b0;
    start  = 1'b0;
    amount = '0;
    repeat (2) @(negedge clk);
    check("rst_outs", {28'd0, out_20, out_10, out_5, out_1}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    check("rst_coins", 32'(coins_out), 32'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);

    // amount = 37, immediate acks: 20,10,5,1,1
    auto_ack = 1'b1; ack_delay = 0;
    o0 = obs_q.size(); d0 = done_cnt;
    do_start(37);
    wait_done("a37", 100);
    check("a37_coins", 32'(coins_out), 32'd5);
    check("a37_remaining", 32'(remaining), 32'd0);
    check("a37_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("a37_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("a37_done_low", 32'(done), 32'd0);
    exp_seq = '{20, 10, 5, 1, 1};
    check_seq("a37", o0, exp_seq);

    // amount = 255: 12 x 20, then 10, then 5
    o0 = obs_q.size(); r0 = rem_q.size();
    do_start(255);
    wait_done("a255", 400);
    check("a255_coins", 32'(coins_out), 32'd14);
    @(negedge clk);
    exp_seq.delete();
    for (int i = 0; i < 12; i++) exp_seq.push_back(20);
    exp_seq.push_back(10);
    exp_seq.push_back(5);
    check_seq("a255", o0, exp_seq);
    exp_rem.delete();
    for (int v = 255; v >= 15; v -= 20) exp_rem.push_back(v);
    exp_rem.push_back(5);
    exp_rem.push_back(0);
    check("a255_rem_len", 32'(rem_q.size() - r0), 32'(exp_rem.size()));
    for (int i = 0; i < exp_rem.size(); i++)
      if (r0 + i < rem_q.size()) check("a255_rem_step", 32'(rem_q[r0 + i]), 32'(exp_rem[i]));

    // amount = 0: done the cycle after the start edge only
    o0 = obs_q.size(); d0 = done_cnt;
    do_start(0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_coins", 32'(coins_out), 32'd0);
    @(negedge clk);
    check("zero_done_low", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("zero_no_coin", 32'(obs_q.size() - o0), 32'd0);
    check("zero_busy_after", 32'(busy), 32'd0);

    // amount = 6, ack held back: out_5 high 10 samples, then out_1
    ack_delay = 9;
    o0 = obs_q.size(); h0 = hi_q.size(); l0 = lo_q.size();
    do_start(6);
    repeat (5) @(negedge clk);
    check("a6_out5_held", 32'(out_5), 32'd1);
    check("a6_rem_held", 32'(remaining), 32'd6);
    wait_done("a6", 100);
    @(negedge clk);
    exp_seq = '{5, 1};
    check_seq("a6", o0, exp_seq);
    if (hi_q.size() > h0) check("a6_out5_high_len", 32'(hi_q[h0]), 32'd10);
    else check("a6_out5_high_len_missing", 32'd0, 32'd1);
    if (lo_q.size() > l0) check("a6_gap_len", 32'(lo_q[l0]), 32'd3);
    else check("a6_gap_len_missing", 32'd0, 32'd1);

    // start while busy is ignored
    ack_delay = 0;
    o0 = obs_q.size();
    do_start(30);
    @(negedge clk);
    do_start(20);
    wait_done("busy_ign", 100);
    check("busy_ign_coins", 32'(coins_out), 32'd2);
    @(negedge clk);
    exp_seq = '{20, 10};
    check_seq("busy_ign", o0, exp_seq);

    // m_rst while out_10 is requested
    auto_ack = 1'b0;
    do_start(10);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_10) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mrst_out10_seen", 32'(got), 32'd1);
    d0 = done_cnt;
    m_rst = 1'b1;
    @(negedge clk);
    m_rst = 1'b0;
    check("mrst_outs", {28'd0, out_20, out_10, out_5, out_1}, 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_remaining", 32'(remaining), 32'd0);
    check("mrst_coins", 32'(coins_out), 32'd0);
    force_ack = 1'b1;
    repeat (4) @(negedge clk);
    force_ack = 1'b0;
    check("mrst_ack_ignored_outs", {28'd0, out_20, out_10, out_5, out_1}, 32'd0);
    check("mrst_ack_ignored_coins", 32'(coins_out), 32'd0);
    check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    auto_ack = 1'b1;
    o0 = obs_q.size();
    do_start(5);
    wait_done("post_mrst", 50);
    check("post_mrst_coins", 32'(coins_out), 32'd1);
    @(negedge clk);
    exp_seq = '{5};
    check_seq("post_mrst", o0, exp_seq);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-return engine for the vending machine: takes a money amount (refund on cancel, or change after purchase) and ejects it as a sequence of physical coins, largest denomination first. It sits between the payment/credit logic and the coin ejector hardware. It is the output-side counterpart of the coin acceptor: the acceptor turns coin events into value, and this block turns value back into coin events. A one-hot eject request is held per coin until the ejector acknowledges it.

## Interface
Parameters:
- AMT_W, 8, width of amount/remaining (max refund 2^AMT_W-1)
- PULSE_GAP, 2, idle cycles between consecutive coin requests (0 = no gap state)

Ports:
- clk  in  1  system clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high; clock clk
- m_rst  in  1  synchronous machine reset; same effect as i_rst at next edge
- start  in  1  request to dispense; sampled only in IDLE
- amount  in  AMT_W  value to return, latched on accepted start
- coin_ack  in  1  ejector confirms current coin dropped
- out_1, out_5, out_10, out_20  out  1  eject request per denomination; at most one high
- busy  out  1  high from accepted start until transaction ends
- done  out  1  one-cycle pulse at end of transaction
- remaining  out  AMT_W  value still to be ejected
- coins_out  out  8  coins ejected in current/last transaction (saturates at 255)

## Operation
- All outputs registered. Reset value: out_x=0, busy=0, done=0, remaining=0, coins_out=0, state IDLE.
- States: IDLE, SELECT, EJECT, GAP.
- IDLE: start=1 and amount!=0 -> remaining<=amount, coins_out<=0, busy<=1, go SELECT. start=1 and amount==0 -> done<=1 for one cycle, coins_out<=0, stay IDLE, no coin requested.
- SELECT: denomination = 20 if remaining>=20, else 10 if >=10, else 5 if >=5, else 1. Assert matching out_x, go EJECT.
- EJECT: hold out_x until coin_ack=1 sampled. On ack: out_x<=0, remaining<=remaining-denom, coins_out+1. If new remaining==0: busy<=0, done<=1, go IDLE. Else go GAP (or SELECT if PULSE_GAP=0).
- GAP: count PULSE_GAP cycles, then SELECT.
- Subtraction never underflows (denom <= remaining by construction).
- start while busy is ignored. amount changes after latch have no effect.
- coin_ack outside EJECT is ignored. A held-high coin_ack acknowledges only one coin per EJECT entry.
- m_rst/i_rst mid-transaction: abort immediately to reset values, no done pulse, out_x dropped.

## Timing
- start sampled at edge N -> SELECT after N -> out_x high after edge N+1 (2-cycle latency).
- coin_ack high at edge M (in EJECT) -> out_x low after M, remaining/coins_out updated after M.
- Next coin request rises after edge M+PULSE_GAP+1 (GAP cycles + SELECT). Minimum out_x low time = PULSE_GAP+1 cycles.
- Last coin: ack at edge M -> done=1 and busy=0 in the cycle after M; done=0 after M+1. A new start is accepted from edge M+1.
- Zero-amount start at edge N -> done=1 in the cycle after N only.
- Out_x with same denomination on consecutive coins always shows a low gap of at least one cycle.

## Test plan
- amount=37, coin_ack pulsed one cycle after each request -> sequence out_20,out_10,out_5,out_1,out_1; coins_out=5, remaining=0, single done pulse, busy low afterwards.
- amount=255 (AMT_W=8) -> 12×out_20, 1×out_10, 1×out_5; coins_out=14; remaining steps 255,235,...,15,5,0.
- amount=0 start -> done high exactly one cycle after start edge, no out_x, busy stays 0.
- amount=6, coin_ack withheld 10 cycles -> out_5 held high 10 cycles, remaining stays 6, then 1 after ack; out_1 rises PULSE_GAP+1 edges after the ack edge.
- start with amount=20 while busy dispensing 30 -> ignored; only 20,10 ejected, coins_out=2.
- m_rst asserted while out_10 high -> next cycle all outputs at reset values, no done; coin_ack afterwards has no effect; a new start works normally.
